// File: rtl/mem_pkg.sv
// Shared definitions for the data memory stage: access size codes, the
// controller state encoding, the default RAM base address and the latched
// request record.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // Request fields captured on the accepting edge.
  typedef struct packed {
    logic        write;
    size_t       size;
    logic        unsgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port word RAM, DEPTH_WORDS x 32, byte-enable synchronous write and
// combinational read. Contents are never reset.
// Ports: clk; we + be[3:0] write strobe/lanes (be[3] = bits 31:24);
//        addr word index; wdata write data; rdata read data of addr.
module data_mem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_stage.sv
// MIPS memory-access stage: byte/half/word big-endian loads and stores into
// an internal RAM with WAIT_STATES extra cycles per access and fault checks.
// Ports: Clk, Reset_n (async, active-low); MEM_Req/Write/Size/Unsigned/Addr/
//        WData request side; MEM_Busy stall, MEM_Done pulse with RData/Error.
module data_mem_stage
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MEM_Req,
  input  logic        MEM_Write,
  input  logic [1:0]  MEM_Size,
  input  logic        MEM_Unsigned,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic [31:0] MEM_RData,
  output logic        MEM_Busy,
  output logic        MEM_Done,
  output logic        MEM_Error
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam int          CW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t      state;
  logic [CW-1:0] cnt;
  req_t        lat;

  logic        accept;
  logic        perform;
  logic [31:0] off;
  logic [1:0]  bo;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] load_val;
  logic [31:0] shifted;
  logic [15:0] half;

  assign accept  = MEM_Req && (state == ST_IDLE || state == ST_DONE);
  assign perform = (state == ST_WAIT) && (cnt == '0);

  // Unsigned offset: addresses below the base wrap to huge values and fault.
  assign off = lat.addr - BASE_ADDR;
  assign bo  = lat.addr[1:0];

  always_comb begin
    fault = 1'b0;
    if (lat.size == SZ_RSVD)                       fault = 1'b1;
    if (lat.size == SZ_HALF && lat.addr[0])        fault = 1'b1;
    if (lat.size == SZ_WORD && lat.addr[1:0] != 0) fault = 1'b1;
    if (off >= SPAN)                               fault = 1'b1;
  end

  // Store lane steering: data replicated across lanes, enables pick the lanes.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = lat.wdata;
    case (lat.size)
      SZ_BYTE: begin
        be         = 4'b1000 >> bo;
        lane_wdata = {4{lat.wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = bo[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{lat.wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  data_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (Clk),
    .we   (perform && lat.write && !fault),
    .be   (be),
    .addr (off[AW+1:2]),
    .wdata(lane_wdata),
    .rdata(ram_rdata)
  );

  // Load: right-justify the selected lane, then extend.
  assign shifted = ram_rdata >> {~bo, 3'b000};
  assign half    = bo[1] ? ram_rdata[15:0] : ram_rdata[31:16];

  always_comb begin
    load_val = ram_rdata;
    case (lat.size)
      SZ_BYTE: load_val = lat.unsgn ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = lat.unsgn ? {16'h0, half} : {{16{half[15]}}, half};
      default: load_val = ram_rdata;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat       <= '0;
      MEM_RData <= '0;
      MEM_Busy  <= 1'b0;
      MEM_Done  <= 1'b0;
      MEM_Error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          MEM_Done  <= 1'b0;
          MEM_Error <= 1'b0;
          MEM_RData <= '0;
          if (accept) begin
            lat.write <= MEM_Write;
            lat.size  <= size_t'(MEM_Size);
            lat.unsgn <= MEM_Unsigned;
            lat.addr  <= MEM_Addr;
            lat.wdata <= MEM_WData;
            cnt       <= CW'(WAIT_STATES);
            MEM_Busy  <= 1'b1;
            state     <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            MEM_Busy  <= 1'b0;
            MEM_Done  <= 1'b1;
            MEM_Error <= fault;
            MEM_RData <= (fault || lat.write) ? 32'h0 : load_val;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
